// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width and data-memory arbiter types.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ARB_HOLD_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1
    } arb_state_e;

endpackage

// File: rtl/riscv_rr_pick2.sv
// Combinational two-way round-robin picker; ptr selects the winner on a conflict.
module riscv_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/riscv_dmem_arb.sv
// Round-robin data-memory arbiter between core (M0) and loader (M1) with bounded lock.
// Define RISCV_DMEM_ARB_STATS_EN to add saturating per-requester wait counters.
module riscv_dmem_arb #(
    parameter int unsigned XLEN     = riscv_pkg::XLEN,
    parameter int unsigned AW       = 30,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_m0_req,
    input  logic            i_m0_we,
    input  logic            i_m0_lock,
    input  logic [XLEN-1:0] i_m0_addr,
    input  logic [XLEN-1:0] i_m0_wdata,
    output logic            o_m0_gnt,
    output logic            o_m0_rvalid,
    output logic [XLEN-1:0] o_m0_rdata,
    input  logic            i_m1_req,
    input  logic            i_m1_we,
    input  logic            i_m1_lock,
    input  logic [XLEN-1:0] i_m1_addr,
    input  logic [XLEN-1:0] i_m1_wdata,
    output logic            o_m1_gnt,
    output logic            o_m1_rvalid,
    output logic [XLEN-1:0] o_m1_rdata,
    output logic [AW-1:0]   o_mem_a,
    output logic [XLEN-1:0] o_mem_d,
    output logic            o_mem_we,
    input  logic [XLEN-1:0] i_mem_spo
`ifdef RISCV_DMEM_ARB_STATS_EN
    ,
    output logic [15:0]     o_m0_wait_cnt,
    output logic [15:0]     o_m1_wait_cnt
`endif
);

    import riscv_pkg::*;

    localparam logic [ARB_HOLD_W-1:0] HOLD_LAST = ARB_HOLD_W'(MAX_HOLD - 1);

    arb_state_e            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [ARB_HOLD_W-1:0] hold_q, hold_d, hold_nxt;
    logic [1:0]            req, pick_gnt, gnt;
    logic                  own, sel, sel_we, sel_lock;
    logic [1:0]            rvalid_q;
    logic [XLEN-1:0]       rdata0_q, rdata1_q;
    logic                  unused_addr;

    assign req         = {i_m1_req, i_m0_req};
    assign unused_addr = ^{i_m0_addr, i_m1_addr};

    riscv_rr_pick2 u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt      = 2'b00;
        own      = (state_q == ARB_OWN1);
        hold_nxt = hold_q + 8'd1;
        unique case (state_q)
            ARB_IDLE: begin
                gnt      = pick_gnt;
                hold_nxt = 8'd1;
            end
            ARB_OWN0, ARB_OWN1: begin
                if (req[own]) begin
                    gnt[own] = 1'b1;
                end else begin
                    // Owner walked away: hand priority to the other side.
                    state_d = ARB_IDLE;
                    hold_d  = '0;
                    ptr_d   = ~own;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (i_rst) begin
            gnt = 2'b00;
        end

        sel      = gnt[1];
        sel_we   = sel ? i_m1_we : i_m0_we;
        sel_lock = sel ? i_m1_lock : i_m0_lock;

        if (gnt != 2'b00) begin
            ptr_d = ~sel;
            // The grant that reaches MAX_HOLD-1 is serviced, then ownership drops.
            if (sel_lock && (hold_nxt < HOLD_LAST)) begin
                state_d = sel ? ARB_OWN1 : ARB_OWN0;
                hold_d  = hold_nxt;
            end else begin
                state_d = ARB_IDLE;
                hold_d  = '0;
            end
        end
    end

    always_comb begin
        o_mem_a  = '0;
        o_mem_d  = '0;
        o_mem_we = 1'b0;
        if (gnt != 2'b00) begin
            o_mem_a  = sel ? i_m1_addr[AW+1:2] : i_m0_addr[AW+1:2];
            o_mem_d  = sel ? i_m1_wdata : i_m0_wdata;
            o_mem_we = sel_we;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= gnt & ~{i_m1_we, i_m0_we};
            if (gnt[0] && !i_m0_we) begin
                rdata0_q <= i_mem_spo;
            end
            if (gnt[1] && !i_m1_we) begin
                rdata1_q <= i_mem_spo;
            end
        end
    end

    assign o_m0_gnt    = gnt[0];
    assign o_m1_gnt    = gnt[1];
    assign o_m0_rvalid = rvalid_q[0];
    assign o_m1_rvalid = rvalid_q[1];
    assign o_m0_rdata  = rdata0_q;
    assign o_m1_rdata  = rdata1_q;

`ifdef RISCV_DMEM_ARB_STATS_EN
    logic [15:0] wait0_q, wait0_d, wait1_q, wait1_d;

    always_comb begin
        wait0_d = wait0_q;
        wait1_d = wait1_q;
        if (req[0] && !gnt[0] && (wait0_q != 16'hFFFF)) begin
            wait0_d = wait0_q + 16'd1;
        end
        if (req[1] && !gnt[1] && (wait1_q != 16'hFFFF)) begin
            wait1_d = wait1_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait0_q <= '0;
            wait1_q <= '0;
        end else begin
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end

    assign o_m0_wait_cnt = wait0_q;
    assign o_m1_wait_cnt = wait1_q;
`endif

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Randomized and directed bench for riscv_dmem_arb against a burst-level ownership model.
module tb_riscv_dmem_arb;

    localparam int XL       = 32;
    localparam int AW       = 30;
    localparam int MAX_HOLD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, we, lock;
    logic [XL-1:0] addr  [2];
    logic [XL-1:0] wdata [2];
    logic          gnt0, gnt1, rv0, rv1, mem_we;
    logic [XL-1:0] rd0, rd1, mem_d, mem_spo;
    logic [AW-1:0] mem_a;
`ifdef RISCV_DMEM_ARB_STATS_EN
    logic [15:0]   wc0, wc1;
`endif

    logic [31:0] tbmem [256];
    logic [31:0] mmem  [256];

    // Model state: current lock owner (-1 none), conflict priority, grants in this burst.
    int          own, ptr, burst;
    logic [1:0]  erv;
    logic [31:0] erd [2];
    int          wexp [2];
    int          checks, errors;

    logic [1:0]    s_gnt, s_rv;
    logic [AW-1:0] s_a;
    logic          s_we;
    logic [31:0]   s_rd0;
    logic [15:0]   s_wc0;

    always #5 clk = ~clk;
    assign mem_spo = tbmem[mem_a[7:0]];

    riscv_dmem_arb #(
        .XLEN     (XL),
        .AW       (AW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_m0_req    (req[0]),
        .i_m0_we     (we[0]),
        .i_m0_lock   (lock[0]),
        .i_m0_addr   (addr[0]),
        .i_m0_wdata  (wdata[0]),
        .o_m0_gnt    (gnt0),
        .o_m0_rvalid (rv0),
        .o_m0_rdata  (rd0),
        .i_m1_req    (req[1]),
        .i_m1_we     (we[1]),
        .i_m1_lock   (lock[1]),
        .i_m1_addr   (addr[1]),
        .i_m1_wdata  (wdata[1]),
        .o_m1_gnt    (gnt1),
        .o_m1_rvalid (rv1),
        .o_m1_rdata  (rd1),
        .o_mem_a     (mem_a),
        .o_mem_d     (mem_d),
        .o_mem_we    (mem_we),
        .i_mem_spo   (mem_spo)
`ifdef RISCV_DMEM_ARB_STATS_EN
        ,
        .o_m0_wait_cnt (wc0),
        .o_m1_wait_cnt (wc1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check();
        logic [1:0]    eg;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic          ewe;
        int            w;
        eg = 2'b00;
        if (!rst) begin
            if (own < 0) begin
                if (req == 2'b11) eg[ptr] = 1'b1;
                else eg = req;
            end else if (req[own]) begin
                eg[own] = 1'b1;
            end
        end
        w   = eg[1] ? 1 : 0;
        ea  = '0;
        ed  = '0;
        ewe = 1'b0;
        if (eg != 2'b00) begin
            ea  = addr[w][AW+1:2];
            ed  = wdata[w];
            ewe = we[w];
        end
        if (rst) begin
            erv     = 2'b00;
            erd[0]  = '0;
            erd[1]  = '0;
            wexp[0] = 0;
            wexp[1] = 0;
        end

        chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
        chk("mem_a", 32'(mem_a), 32'(ea));
        chk("mem_d", mem_d, ed);
        chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        chk("rvalid", {30'd0, rv1, rv0}, {30'd0, erv});
        chk("rdata0", rd0, erd[0]);
        chk("rdata1", rd1, erd[1]);
`ifdef RISCV_DMEM_ARB_STATS_EN
        chk("wait0", {16'd0, wc0}, 32'(wexp[0]));
        chk("wait1", {16'd0, wc1}, 32'(wexp[1]));
        s_wc0 = wc0;
`else
        s_wc0 = '0;
`endif
        s_gnt = {gnt1, gnt0};
        s_rv  = {rv1, rv0};
        s_a   = mem_a;
        s_we  = mem_we;
        s_rd0 = rd0;

        if (rst) begin
            own   = -1;
            ptr   = 0;
            burst = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                erv[i] = eg[i] & ~we[i];
                if (eg[i] && !we[i]) erd[i] = mmem[addr[i][9:2]];
                if (eg[i] && we[i]) mmem[addr[i][9:2]] = wdata[i];
                if (req[i] && !eg[i] && wexp[i] < 65535) wexp[i]++;
            end
            if (eg != 2'b00) begin
                burst = (own < 0) ? 1 : burst + 1;
                if (lock[w] && burst < MAX_HOLD - 1) begin
                    own = w;
                end else begin
                    own   = -1;
                    burst = 0;
                end
                ptr = 1 - w;
            end else if (own >= 0) begin
                ptr   = 1 - own;
                own   = -1;
                burst = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check();
        if (mem_we) tbmem[mem_a[7:0]] = mem_d;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic r, input logic w_, input logic l,
                         input logic [31:0] a, input logic [31:0] d);
        req[i]   = r;
        we[i]    = w_;
        lock[i]  = l;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n1, kfound;
        checks = 0;
        errors = 0;
        own    = -1;
        ptr    = 0;
        burst  = 0;
        erv    = 2'b00;
        erd[0] = '0;
        erd[1] = '0;
        wexp[0] = 0;
        wexp[1] = 0;
        for (int k = 0; k < 256; k++) begin
            tbmem[k] = $urandom;
            mmem[k]  = tbmem[k];
        end
        rst = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h1111_1111);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h2222_2222);

        // Reset state: no grant, no write, no read return.
        tick();
        chk("rst_gnt", {30'd0, s_gnt}, 32'd0);
        chk("rst_we", {31'd0, s_we}, 32'd0);
        chk("rst_rvalid", {30'd0, s_rv}, 32'd0);
        rst = 1'b0;

        // Single write then read.
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("wr_gnt", {30'd0, s_gnt}, 32'd1);
        chk("wr_mem_a", 32'(s_a), 32'd4);
        chk("wr_we", {31'd0, s_we}, 32'd1);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        chk("rd_gnt", {30'd0, s_gnt}, 32'd1);
        chk("rd_mem_a", 32'(s_a), 32'd4);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("rd_rvalid", {30'd0, s_rv}, 32'd1);
        chk("rd_data", s_rd0, 32'hDEAD_BEEF);

        // Round-robin alternation from reset.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", {30'd0, s_gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        req = 2'b00;
        tick();

        // Locked four-word burst from M1 while M0 waits.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) set_m(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
            set_m(1, 1'b1, 1'b1, (k < 3), 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            tick();
            chk("burst_gnt1", {30'd0, s_gnt}, 32'd2);
        end
        req[1] = 1'b0;
        tick();
        chk("burst_then_gnt0", {30'd0, s_gnt}, 32'd1);
        req = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("burst_mem", tbmem[64 + k], 32'hA000_0000 + 32'(k));
        end

        // MAX_HOLD cap with M1 locked continuously.
        do_reset();
        n1     = 0;
        kfound = -1;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) set_m(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h5555_0000);
            set_m(1, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hB000_0000 + 32'(k));
            tick();
            if (s_gnt[1]) n1++;
            if (s_gnt[0]) begin
                kfound = k;
                break;
            end
        end
        chk("cap_m1_grants", 32'(n1), 32'd7);
        chk("cap_m0_gnt_cycle", 32'(kfound), 32'd7);
        chk("cap_wait_bound", {31'd0, (kfound > 0) && (kfound - 1 <= MAX_HOLD)}, 32'd1);
        req = 2'b00;
        tick();

        // Reset in the cycle after an M0 read grant.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        chk("rm_rd_gnt", {30'd0, s_gnt}, 32'd1);
        rst = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h7777_7777);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h18, 32'h8888_8888);
        tick();
        chk("rm_rvalid", {30'd0, s_rv}, 32'd0);
        chk("rm_we", {31'd0, s_we}, 32'd0);
        chk("rm_gnt", {30'd0, s_gnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rm_first_conflict", {30'd0, s_gnt}, 32'd1);
        req = 2'b00;
        tick();

        // Randomized traffic obeying the hold-until-grant rule, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (s_gnt[i] || !req[i]) begin
                    if ($urandom_range(99) < 65) begin
                        set_m(i, 1'b1, 1'($urandom_range(1)), ($urandom_range(99) < 60),
                              {22'd0, 8'($urandom), 2'($urandom)}, $urandom);
                    end else begin
                        set_m(i, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                              {22'd0, 8'($urandom), 2'($urandom)}, $urandom);
                    end
                end
            end
            rst = ($urandom_range(199) == 0);
        end
        rst = 1'b0;
        req = 2'b00;
        tick();

`ifdef RISCV_DMEM_ARB_STATS_EN
        // M0 blocked for five cycles by an M1 lock.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 1) set_m(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
            set_m(1, 1'b1, 1'b1, (k < 5), 32'h80 + 32'(4 * k), 32'(k));
            tick();
        end
        req[1] = 1'b0;
        tick();
        chk("stats_wait5", {16'd0, s_wc0}, 32'd5);
        chk("stats_wait5_gnt", {30'd0, s_gnt}, 32'd1);
        req = 2'b00;
        tick();

        // Long contention: M0 waits seven of every eight cycles until saturation.
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        for (int c = 0; c < 75000; c++) begin
            tick();
        end
        chk("stats_saturate", {16'd0, s_wc0}, 32'h0000_FFFF);
        req = 2'b00;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_arb.md
Name: riscv_dmem_arb

Overview:
- Two-requester arbiter that shares the single-port data memory (write clocked, read combinational) between the core's load/store port (M0) and a debug/program-loader port (M1).
- Sits between the requesters and data_mem, ahead of the memory-mapped IO decode.
- Provides round-robin arbitration, an optional bounded lock for multi-word bursts, and a registered read-return path.

Parameters:
- XLEN, riscv_pkg::XLEN (32): address and data width.
- AW, 30: memory word-address width; the word address is addr[AW+1:2].
- MAX_HOLD, 8: maximum consecutive cycles one locked owner may hold the memory; legal range 2 to 255.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_m0_req  in  1  core access request.
- i_m0_we  in  1  core write enable.
- i_m0_lock  in  1  core requests to keep ownership after this access.
- i_m0_addr  in  XLEN  core byte address.
- i_m0_wdata  in  XLEN  core write data.
- o_m0_gnt  out  1  core access accepted this cycle.
- o_m0_rvalid  out  1  core read data valid.
- o_m0_rdata  out  XLEN  core read data.
- i_m1_req, i_m1_we, i_m1_lock, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as the M0 ports, for the loader.
- o_mem_a  out  AW  memory word address.
- o_mem_d  out  XLEN  memory write data.
- o_mem_we  out  1  memory write enable.
- i_mem_spo  in  XLEN  memory combinational read data.

Behaviour:
- **Reset values:** state IDLE, rr_ptr=0 (M0 preferred), hold_cnt=0, o_mX_rvalid=0, o_mX_rdata=0. While i_rst is high, o_mX_gnt=0 and o_mem_we=0.
- **States:** IDLE, OWN0, OWN1.
- **Grant selection in IDLE:**
  - Only one request: grant it.
  - Both requests: grant the requester indicated by rr_ptr.
  - After any IDLE grant, rr_ptr points to the other requester.
- **Grant selection in OWNx:** grant only Mx if i_mx_req=1. The other requester gets gnt=0.
- **Grant timing:** gnt is combinational in the same cycle as req. At most one gnt is high at a time.
- **Memory drive:**
  - o_mem_a/o_mem_d/o_mem_we follow the granted requester: o_mem_we = gnt & we.
  - With no grant: o_mem_we=0, o_mem_a=0, o_mem_d=0.
- **Read return:** on a granted read (gnt & ~we), i_mem_spo is registered into o_mx_rdata, and o_mx_rvalid=1 in the next cycle only. rvalid stays 0 for writes. rdata holds its value when rvalid=0.
- **Requester rule:** a requester must hold req and its address/data stable until gnt is seen.
- **Lock transitions:**
  - A granted access with lock=1 moves the state (or keeps it) to OWNx.
  - On the first locked grant, hold_cnt loads 1. Each further locked grant in OWNx increments hold_cnt.
  - OWNx returns to IDLE when any of these occurs:
    - lock=0 on a grant;
    - Mx drops req;
    - hold_cnt reaches MAX_HOLD-1 on a grant. That grant is still serviced, then ownership is released.
  - On release, hold_cnt clears and rr_ptr points to the other requester.
- **Starvation bound:** the non-owner waits at most MAX_HOLD cycles once the owner is locked. A MAX_HOLD-triggered release always returns to IDLE. rr_ptr then points to the waiter, so the waiter is granted next if it is requesting.
- **Simultaneous events:**
  - A request from the other side while OWNx is releasing is granted in the following cycle, not the same cycle.
  - lock without req is ignored.
- **Reset mid-operation:**
  - A pending rvalid is cleared.
  - A write in the reset cycle is suppressed.
  - The state returns to IDLE immediately, because reset is asynchronous.
- **Addressing:** the byte address bits [1:0] are ignored. IO-region decode (addr MSB) is done downstream of this block.

Optional Feature:
- **Macro:** RISCV_DMEM_ARB_STATS_EN.
- **When defined:** adds outputs o_m0_wait_cnt and o_m1_wait_cnt, each 16 bits. A counter increments every cycle that Mx has req=1 and gnt=0, and saturates at 16'hFFFF. Both counters clear on reset.
- **When not defined:** the ports and counters are absent, and the core arbitration behaviour is identical.

Decomposition:
- **riscv_pkg additions:**
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_OWN0, ARB_OWN1};
  - localparam ARB_HOLD_W = 8.
- **Sub-module riscv_rr_pick2:** a combinational two-way round-robin picker. Inputs are req[1:0] and ptr; output is gnt one-hot. It is instantiated once, for IDLE-state selection.

Test Plan:
- **Single write then read:** M0 writes addr 0x10 with 0xDEADBEEF, then reads 0x10 → gnt0 high in both cycles, o_mem_a=4, rvalid0 one cycle after the read, rdata0=0xDEADBEEF.
- **Round-robin alternation:** M0 and M1 both request continuously without lock from reset → grants alternate 0,1,0,1. o_mem_we is never asserted for the non-granted requester.
- **Locked burst:** M1 writes 4 words with lock=1 at 0x100..0x10C while M0 requests → gnt1 for 4 cycles, then gnt0 in cycle 5. Memory words 64..67 are written.
- **MAX_HOLD cap:** MAX_HOLD=8, M1 locked continuously, M0 requesting → M1 gets 7 grants, M0 is granted on the next cycle, and its wait count is ≤ 8.
- **Reset mid-read:** i_rst asserted in the cycle after an M0 read grant → rvalid0=0, state IDLE, no write occurs. The first post-reset conflict goes to M0.
- **Stats (RISCV_DMEM_ARB_STATS_EN):** M0 blocked 5 cycles by an M1 lock → o_m0_wait_cnt=5. After 70000 blocked cycles, o_m0_wait_cnt reads 0xFFFF (saturated).
